alu_seq_core: RTL
=================

Name: alu_seq_core

Overview:
Parametrised, clocked successor to the 4-bit combinational ALU on the tile.
- Accepts operand pairs over a valid/ready handshake.
- Executes single-cycle logic/arithmetic ops, plus multi-cycle shift-add multiply and restoring divide.
- Keeps an accumulator for chained operations.
- Returns a 2*WIDTH-bit result with status flags over a second valid/ready handshake.
- Sits between the pin-level tile wrapper and its operand/opcode capture logic.

Parameters:
WIDTH, 8, operand width in bits (>=4); result is 2*WIDTH bits.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset: asynchronous, active-high; clears all state
in_valid  input  1  operand/opcode presented
in_ready  output  1  block can accept (high only in IDLE)
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B
sel  input  3  opcode
use_acc  input  1  replace op_a with accumulator
out_valid  output  1  result/flags valid
out_ready  input  1  consumer takes result
result  output  2*WIDTH  result
flag_z  output  1  result == 0 (all 2*WIDTH bits)
flag_c  output  1  carry/borrow/overflow-out (per op)
flag_v  output  1  signed overflow (ADD/SUB only)
div_err  output  1  last DIV had op_b == 0
busy  output  1  state != IDLE

Behaviour:
- Reset (async, active-high):
  - state = IDLE; acc = 0; iteration counter = 0.
  - result, flags, div_err, out_valid, busy all 0.
  - in_ready = 1 (combinational, state == IDLE).
- Accept: in_valid & in_ready on a rising edge latches a_eff = (use_acc ? acc : op_a), op_b and sel.
- Opcodes; result upper half is 0 unless stated:
  - 000 ADD: low = a+b mod 2^W; C = carry out; V = signed overflow.
  - 001 SUB: low = a-b mod 2^W; C = borrow (a<b unsigned); V = signed overflow.
  - 010 AND; 011 OR; 100 XOR: bitwise; C = V = 0.
  - 101 SHL: sh = b mod WIDTH; low = (a<<sh) truncated to W; C = OR of bits shifted out; V = 0.
  - 110 MUL: unsigned, full 2*WIDTH product; C = (upper half != 0); V = 0.
  - 111 DIV: unsigned; low = quotient, upper = remainder; C = V = 0.
  - DIV with b == 0: quotient = all ones, remainder = a, div_err = 1; takes the single-cycle path.
  - div_err updates on every completed op (0 for all non-DIV ops).
- FSM: IDLE, EXEC, DONE.
  - IDLE --accept, single-cycle op (incl. DIV by 0)--> DONE. Result is registered on the accept edge; out_valid is high the next cycle (latency 1).
  - IDLE --accept, MUL or DIV (b != 0)--> EXEC; counter = WIDTH-1.
  - EXEC: one shift-add / restore-subtract step per cycle; counter decrements. At counter == 0 the final step is written to result/flags and the FSM goes to DONE.
  - MUL/DIV: out_valid is asserted WIDTH cycles after the accept edge (WIDTH EXEC cycles).
  - DONE: out_valid = 1; result and flags held stable. On out_valid & out_ready: out_valid drops, FSM returns to IDLE.
  - A new accept is possible only in the cycle after the output handshake (no same-cycle overlap).
- acc is loaded with result[WIDTH-1:0] on the edge entering DONE.
- in_valid is ignored outside IDLE; operands changing during EXEC have no effect.
- out_ready is ignored outside DONE.
- rst asserted mid-EXEC or in DONE aborts immediately (async). The pending result is discarded and acc = 0.
- No combinational path from in_valid or out_ready to any output except through state.

Test Plan:
- WIDTH=8: ADD a=0xF0, b=0x20 -> out_valid 1 cycle after accept; result=0x0010, C=1, V=0, Z=0. SUB a=0x80, b=0x01 -> 0x007F, V=1, C=0.
- MUL a=0xFF, b=0xFF -> out_valid exactly 8 cycles after accept; result=0xFE01, C=1; busy high throughout; in_ready low until the output handshake.
- DIV a=200, b=7 -> result=0x041C (rem 4, quot 28), div_err=0. DIV a=0x55, b=0 -> result=0x55FF, div_err=1, latency 1.
- Accumulator chain: ADD 5+3, then use_acc=1 ADD with b=2 -> 0x000A. Hold out_ready low 5 cycles -> result and out_valid stable, second in_valid not accepted.
- Reset asserted mid-MUL EXEC (cycle 4) -> outputs 0 and in_ready 1 immediately. Post-reset use_acc ADD with b=9 -> 0x0009. SHL a=0x81, b=0x09 (sh=1) -> 0x0002, C=1.

Source files
------------

// File: rtl/alu_seq_core.sv
// alu_seq_core: clocked ALU with a valid/ready handshake on both sides.
// Most ops complete on the accept edge. MUL (shift-add) and DIV (restoring)
// iterate one bit per cycle. An accumulator can stand in for operand A so
// that operations can be chained.
module alu_seq_core #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic [2:0]         sel,
  input  logic               use_acc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               flag_z,
  output logic               flag_c,
  output logic               flag_v,
  output logic               div_err,
  output logic               busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] W_VAL   = WIDTH'(WIDTH);
  localparam logic [CW-1:0]    CNT_TOP = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   a_r, b_r;
  logic               is_div;
  // {hi,lo}: partial product (MUL) or {remainder, dividend/quotient} (DIV)
  logic [WIDTH-1:0]   hi, lo;

  logic [WIDTH-1:0]   a_eff;
  logic               accept, go_iter;
  logic [WIDTH:0]     add_w, sub_w;
  logic [WIDTH-1:0]   sh;
  logic [2*WIDTH-1:0] shl_w;
  logic [2*WIDTH-1:0] sc_res;
  logic               sc_c, sc_v, sc_err;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh, div_sub;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] step_nxt;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid & in_ready;
  assign a_eff     = use_acc ? acc : op_a;
  assign go_iter   = (sel == OP_MUL) || ((sel == OP_DIV) && (op_b != '0));

  // Single-cycle result path, evaluated from the live operands at accept
  always_comb begin
    add_w  = {1'b0, a_eff} + {1'b0, op_b};
    sub_w  = {1'b0, a_eff} - {1'b0, op_b};
    sh     = op_b % W_VAL;
    shl_w  = {{WIDTH{1'b0}}, a_eff} << sh;
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_err = 1'b0;
    case (sel)
      OP_ADD: begin
        sc_res[WIDTH-1:0] = add_w[WIDTH-1:0];
        sc_c = add_w[WIDTH];
        sc_v = (a_eff[WIDTH-1] == op_b[WIDTH-1]) && (add_w[WIDTH-1] != a_eff[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res[WIDTH-1:0] = sub_w[WIDTH-1:0];
        sc_c = sub_w[WIDTH];
        sc_v = (a_eff[WIDTH-1] != op_b[WIDTH-1]) && (sub_w[WIDTH-1] != a_eff[WIDTH-1]);
      end
      OP_AND: sc_res[WIDTH-1:0] = a_eff & op_b;
      OP_OR:  sc_res[WIDTH-1:0] = a_eff | op_b;
      OP_XOR: sc_res[WIDTH-1:0] = a_eff ^ op_b;
      OP_SHL: begin
        sc_res[WIDTH-1:0] = shl_w[WIDTH-1:0];
        sc_c = |shl_w[2*WIDTH-1:WIDTH];
      end
      // only reached here on divide-by-zero; real divides iterate
      OP_DIV: begin
        sc_res = {a_eff, {WIDTH{1'b1}}};
        sc_err = 1'b1;
      end
      default: ;
    endcase
  end

  // One iteration step: shift-add multiply or restoring-divide bit
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, a_r} : '0);
    div_sh  = {hi, lo[WIDTH-1]};
    div_sub = div_sh - {1'b0, b_r};
    div_ge  = (div_sh >= {1'b0, b_r});
    div_rem = div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
    if (is_div)
      step_nxt = {div_rem, lo[WIDTH-2:0], div_ge};
    else
      step_nxt = {mul_sum, lo[WIDTH-1:1]};
  end

  // FSM, iteration datapath, result/flag and accumulator registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      is_div  <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      result  <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      flag_v  <= 1'b0;
      div_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (go_iter) begin
              state  <= EXEC;
              cnt    <= CNT_TOP;
              a_r    <= a_eff;
              b_r    <= op_b;
              is_div <= (sel == OP_DIV);
              hi     <= '0;
              lo     <= (sel == OP_DIV) ? a_eff : op_b;
            end else begin
              state   <= DONE;
              result  <= sc_res;
              flag_z  <= (sc_res == '0);
              flag_c  <= sc_c;
              flag_v  <= sc_v;
              div_err <= sc_err;
              acc     <= sc_res[WIDTH-1:0];
            end
          end
        end
        EXEC: begin
          {hi, lo} <= step_nxt;
          cnt      <= cnt - 1'b1;
          if (cnt == '0) begin
            state   <= DONE;
            result  <= step_nxt;
            flag_z  <= (step_nxt == '0);
            flag_c  <= is_div ? 1'b0 : (step_nxt[2*WIDTH-1:WIDTH] != '0);
            flag_v  <= 1'b0;
            div_err <= 1'b0;
            acc     <= step_nxt[WIDTH-1:0];
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
